// File: rtl/btn_debounce_pkg.sv
// Shared types and defaults for the push-button conditioning path (package btn_pkg).
// State encoding and the idle polarity mask are also used by the downstream status block.
package btn_pkg;

    typedef enum logic [1:0] {
        REL   = 2'b00,
        PWAIT = 2'b01,
        PRS   = 2'b11,
        RWAIT = 2'b10
    } btn_state_e;

    localparam logic [5:0] BTN_ACTIVE_LOW_MASK   = 6'b000011;
    localparam int         BTN_DEBOUNCE_DEFAULT  = 1000000;
    localparam int         BTN_CNT_W_DEFAULT     = 20;

endpackage

// File: rtl/btn_debounce_if.sv
// Button conditioning bus: raw pads in, debounced levels and strobes out.
// BTN_RELEASE_PULSE_EN adds the release_pulse strobe.
interface btn_debounce_if #(
    parameter int N_BTN = 6
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] an;
    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] press_pulse;
`ifdef BTN_RELEASE_PULSE_EN
    logic [N_BTN-1:0] release_pulse;

    modport master (output btn_raw, input an, press, press_pulse, release_pulse);
    modport slave  (input btn_raw, output an, press, press_pulse, release_pulse);
`else
    modport master (output btn_raw, input an, press, press_pulse);
    modport slave  (input btn_raw, output an, press, press_pulse);
`endif
endinterface

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, stable-count debounce FSM, registered outputs.
// BTN_RELEASE_PULSE_EN adds a one-cycle strobe on accepted release.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT,
    parameter int   CNT_W           = BTN_CNT_W_DEFAULT,
    parameter logic ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic an,
    output logic press,
`ifdef BTN_RELEASE_PULSE_EN
    output logic release_pulse,
`endif
    output logic press_pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       sync_d, sync_q;
    btn_state_e       state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             press_d, press_q;
    logic             an_d, an_q;
    logic             press_pulse_d, press_pulse_q;
    logic             s;
`ifdef BTN_RELEASE_PULSE_EN
    logic             release_pulse_d, release_pulse_q;
`endif

    // s is 1 when the synchronised pad reads "pressed", whatever the pad polarity
    assign s      = sync_q[1] ^ ACTIVE_LOW;
    assign sync_d = {sync_q[0], btn_raw};

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        press_pulse_d = 1'b0;
`ifdef BTN_RELEASE_PULSE_EN
        release_pulse_d = 1'b0;
`endif
        case (state_q)
            REL: begin
                if (s) begin
                    state_d = PWAIT;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            PWAIT: begin
                if (!s) begin
                    state_d = REL;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = PRS;
                    cnt_d         = '0;
                    press_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRS: begin
                if (!s) begin
                    state_d = RWAIT;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            RWAIT: begin
                if (s) begin
                    state_d = PRS;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = REL;
                    cnt_d   = '0;
`ifdef BTN_RELEASE_PULSE_EN
                    release_pulse_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = REL;
                cnt_d   = '0;
            end
        endcase
        // Outputs follow the next state so press and press_pulse rise on the same edge
        press_d = (state_d == PRS) || (state_d == RWAIT);
        an_d    = press_d ^ ACTIVE_LOW;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q        <= {2{ACTIVE_LOW}};
            state_q       <= REL;
            cnt_q         <= '0;
            press_q       <= 1'b0;
            an_q          <= ACTIVE_LOW;
            press_pulse_q <= 1'b0;
`ifdef BTN_RELEASE_PULSE_EN
            release_pulse_q <= 1'b0;
`endif
        end else begin
            sync_q        <= sync_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            press_q       <= press_d;
            an_q          <= an_d;
            press_pulse_q <= press_pulse_d;
`ifdef BTN_RELEASE_PULSE_EN
            release_pulse_q <= release_pulse_d;
`endif
        end
    end

    assign an          = an_q;
    assign press       = press_q;
    assign press_pulse = press_pulse_q;
`ifdef BTN_RELEASE_PULSE_EN
    assign release_pulse = release_pulse_q;
`endif

endmodule

// File: rtl/btn_debounce.sv
// N_BTN independent debounce channels presented on one bus.
// BTN_RELEASE_PULSE_EN adds release_pulse to the bus.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int               N_BTN           = 6,
    parameter int               DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT,
    parameter int               CNT_W           = BTN_CNT_W_DEFAULT,
    parameter logic [N_BTN-1:0] ACTIVE_LOW_MASK = N_BTN'(BTN_ACTIVE_LOW_MASK)
) (
    input logic           clk,
    input logic           rst,
    btn_debounce_if.slave bus
);

    logic [N_BTN-1:0] an_w;
    logic [N_BTN-1:0] press_w;
    logic [N_BTN-1:0] press_pulse_w;
`ifdef BTN_RELEASE_PULSE_EN
    logic [N_BTN-1:0] release_pulse_w;
`endif

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W),
            .ACTIVE_LOW     (ACTIVE_LOW_MASK[g])
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .btn_raw      (bus.btn_raw[g]),
            .an           (an_w[g]),
            .press        (press_w[g]),
`ifdef BTN_RELEASE_PULSE_EN
            .release_pulse(release_pulse_w[g]),
`endif
            .press_pulse  (press_pulse_w[g])
        );
    end

    assign bus.an          = an_w;
    assign bus.press       = press_w;
    assign bus.press_pulse = press_pulse_w;
`ifdef BTN_RELEASE_PULSE_EN
    assign bus.release_pulse = release_pulse_w;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Debouncer bench: directed scenarios plus random bouncing, checked against a run-length model.
// Honours BTN_RELEASE_PULSE_EN when defined.
module tb_btn_debounce;
    localparam int         N    = 6;
    localparam int         DC   = 4;
    localparam logic [5:0] MASK = 6'b000011;

    logic clk;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    btn_debounce_if #(.N_BTN(N)) bus_if ();

    btn_debounce #(
        .N_BTN          (N),
        .DEBOUNCE_CYCLES(DC),
        .CNT_W          (3),
        .ACTIVE_LOW_MASK(MASK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: raw delayed two samples, level flips after DC consecutive disagreeing samples
    logic [5:0] hist0, hist1, lvl, m_pulse, m_rpulse;
    int         run [N];

    task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic [5:0] raw);
        logic [5:0] s;
        m_pulse  = '0;
        m_rpulse = '0;
        if (r) begin
            hist0 = MASK;
            hist1 = MASK;
            lvl   = '0;
            for (int i = 0; i < N; i++) run[i] = 0;
        end else begin
            s     = hist1 ^ MASK;
            hist1 = hist0;
            hist0 = raw;
            for (int i = 0; i < N; i++) begin
                if (s[i] != lvl[i]) begin
                    run[i]++;
                    if (run[i] == DC) begin
                        lvl[i] = s[i];
                        run[i] = 0;
                        if (s[i]) m_pulse[i] = 1'b1;
                        else      m_rpulse[i] = 1'b1;
                    end
                end else begin
                    run[i] = 0;
                end
            end
        end
    endtask

    task automatic step(input logic [5:0] raw, input logic r);
        @(negedge clk);
        bus_if.btn_raw = raw;
        rst            = r;
        @(posedge clk);
        model_edge(r, raw);
        #1;
        chk("an", bus_if.an, lvl ^ MASK);
        chk("press", bus_if.press, lvl);
        chk("press_pulse", bus_if.press_pulse, m_pulse);
`ifdef BTN_RELEASE_PULSE_EN
        chk("release_pulse", bus_if.release_pulse, m_rpulse);
`endif
    endtask

    logic [5:0] cur;
    int         hold [N];

    initial begin
        rst            = 1'b1;
        bus_if.btn_raw = MASK;
        hist0 = MASK; hist1 = MASK; lvl = '0; m_pulse = '0; m_rpulse = '0;
        for (int i = 0; i < N; i++) run[i] = 0;

        // Reset
        step(MASK, 1'b1);
        step(MASK, 1'b1);
        chk("rst_an", bus_if.an, 6'b000011);
        chk("rst_press", bus_if.press, 6'b000000);

        // Clean press on channel 2
        for (int i = 1; i <= 8; i++) begin
            step(6'b000111, 1'b0);
            if (i == 5) chk("clean_press_c5", bus_if.press, 6'b000000);
            if (i == 6) chk("clean_pulse_c6", bus_if.press_pulse, 6'b000100);
            if (i == 6) chk("clean_an_c6", bus_if.an, 6'b000111);
            if (i == 7) chk("clean_pulse_c7", bus_if.press_pulse, 6'b000000);
        end
        for (int i = 0; i < 8; i++) step(MASK, 1'b0);

        // Active-low channel 0 bouncing, then held pressed
        step(6'b000011, 1'b0); step(6'b000010, 1'b0);
        step(6'b000011, 1'b0); step(6'b000010, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            step(6'b000010, 1'b0);
            if (i == 5) chk("bounce_an_c6", bus_if.an, 6'b000010);
        end
        for (int i = 0; i < 8; i++) step(MASK, 1'b0);

        // Glitch of DC-1 samples rejected, then exactly DC accepted
        for (int i = 0; i < 3; i++) step(6'b010011, 1'b0);
        for (int i = 0; i < 8; i++) step(MASK, 1'b0);
        chk("glitch3_press", bus_if.press, 6'b000000);
        for (int i = 0; i < 4; i++) step(6'b010011, 1'b0);
        for (int i = 0; i < 10; i++) step(MASK, 1'b0);
        chk("glitch4_released", bus_if.press, 6'b000000);

        // Reset while channel 3 is mid-qualification
        for (int i = 0; i < 4; i++) step(6'b001011, 1'b0);
        step(6'b001011, 1'b1);
        chk("midrst_press", bus_if.press, 6'b000000);
        for (int i = 1; i <= 6; i++) begin
            step(6'b001011, 1'b0);
            if (i == 5) chk("midrst_c5", bus_if.press, 6'b000000);
            if (i == 6) chk("midrst_c6", bus_if.press, 6'b001000);
        end
        for (int i = 0; i < 8; i++) step(MASK, 1'b0);

        // Channels 1 and 5 pressed and released together
        for (int i = 1; i <= 8; i++) begin
            step(6'b100001, 1'b0);
            if (i == 6) chk("multi_pulse", bus_if.press_pulse, 6'b100010);
        end
        for (int i = 1; i <= 8; i++) begin
            step(MASK, 1'b0);
`ifdef BTN_RELEASE_PULSE_EN
            if (i == 6) chk("multi_release", bus_if.release_pulse, 6'b100010);
`endif
            if (i == 6) chk("multi_press_off", bus_if.press, 6'b000000);
        end

        // Random per-channel hold lengths around the debounce threshold, rare resets
        cur = MASK;
        for (int i = 0; i < N; i++) hold[i] = 1;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                hold[i]--;
                if (hold[i] <= 0) begin
                    cur[i]  = ~cur[i];
                    hold[i] = int'($urandom_range(1, 8));
                end
            end
            step(cur, ($urandom_range(0, 299) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Upstream conditioning stage for the board push-buttons. Feeds the button/LED status block, which samples a 6-bit `an` vector.
- Per channel: synchronises the raw pad, debounces it with a stable-count filter, and presents a clean level in the pad's native polarity (bits [1:0] active-low, [5:2] active-high).
- Also produces a one-cycle, active-high press pulse per channel for event-driven consumers.

Parameters:
- N_BTN, 6, number of button channels.
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised samples needed to accept a change. 10 ms at 100 MHz. Legal range is 2 or more.
- CNT_W, 20, counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- ACTIVE_LOW_MASK, 6'b000011, bit i = 1 means channel i is pressed when its pad is low.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- btn_raw  in  N_BTN  asynchronous pad inputs, native polarity.
- an  out  N_BTN  debounced levels, native polarity. Drives the downstream status block directly.
- press  out  N_BTN  active-high pressed level. Equals an XOR ACTIVE_LOW_MASK.
- press_pulse  out  N_BTN  one-cycle strobe on each accepted press.

Behaviour:
- Synchroniser: 2-FF chain per channel, `sync = btn_raw` delayed 2 clocks. Reset clears the chain to the idle value ACTIVE_LOW_MASK[i].
- Normalisation: `s_i = sync_i XOR ACTIVE_LOW_MASK[i]`, so 1 means pressed.
- Per-channel FSM states:
  - REL (stable released)
  - PWAIT (press pending)
  - PRS (stable pressed)
  - RWAIT (release pending)
- Transitions (cnt is the per-channel counter, CNT_W bits):
  - REL: if s=1, go to PWAIT and set cnt=1; otherwise cnt=0.
  - PWAIT: if s=0, return to REL and set cnt=0 (bounce). Else if cnt==DEBOUNCE_CYCLES-1, go to PRS, set cnt=0 and assert press_pulse for one cycle. Else cnt+1.
  - PRS: if s=0, go to RWAIT and set cnt=1.
  - RWAIT: if s=1, return to PRS and set cnt=0. Else if cnt==DEBOUNCE_CYCLES-1, go to REL and set cnt=0. Else cnt+1.
- Outputs are registered:
  - press_i = 1 in PRS or RWAIT.
  - `an_i = press_i XOR ACTIVE_LOW_MASK[i]`.
- Latency: a clean edge on btn_raw held stable is reflected on an/press exactly 2+DEBOUNCE_CYCLES clocks later. press_pulse asserts in the same cycle that press first rises.
- The counter never wraps. It is only compared against DEBOUNCE_CYCLES-1 and is cleared on every state change.
- A glitch shorter than DEBOUNCE_CYCLES synchronised samples causes no output change and no pulse. A glitch of exactly DEBOUNCE_CYCLES samples is accepted.
- Channels are fully independent. Simultaneous presses on several channels give simultaneous pulses.
- Reset values:
  - FSM = REL, cnt = 0.
  - an = ACTIVE_LOW_MASK (all released), press = 0, press_pulse = 0.
- Reset mid-operation (any state, any count) returns to the reset values on the next edge. A button held through reset is re-qualified as a fresh press with full latency after rst falls.
- No combinational path from btn_raw to any output.

Optional Feature:
- Macro: BTN_RELEASE_PULSE_EN.
- When defined: an extra output port `release_pulse` (N_BTN, out) is added. It strobes for one cycle on the RWAIT→REL transition and resets to 0.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package btn_pkg holds:
  - the 2-bit state encoding: REL=2'b00, PWAIT=2'b01, PRS=2'b11, RWAIT=2'b10;
  - the default ACTIVE_LOW_MASK constant shared with the downstream status block;
  - a default-debounce constant.
- Sub-module btn_debounce_ch: one channel, containing the sync chain, FSM, counter and output registers. The top generates N_BTN instances and concatenates their outputs.

Test Plan (DEBOUNCE_CYCLES=4 unless noted):
- Reset check: rst=1 for 2 cycles, btn_raw=6'b000011 → an=6'b000011, press=0, press_pulse=0 throughout.
- Clean press: btn_raw[2] rises at cycle 0 and holds → press[2]=1, an[2]=1 and press_pulse[2]=1 at cycle 6 only. press_pulse[2]=0 at cycle 7.
- Active-low press with bounce: btn_raw[0] toggles 1-0-1-0 on consecutive cycles, then holds 0 → no pulse during the toggles. an[0] goes 0 and press[0]=1 six cycles after the final stable 0.
- Glitch rejection: btn_raw[4] high for 3 cycles, then low → an, press and press_pulse unchanged. Repeat with 4 cycles high → exactly one press_pulse[4], followed by a release 6 cycles after the fall.
- Reset mid-qualify: hold btn_raw[3]=1, assert rst during PWAIT with cnt=2 → outputs stay at reset values. press[3] rises 6 cycles after rst deasserts.
- Multi-channel plus macro: with BTN_RELEASE_PULSE_EN, channels 1 and 5 are pressed together and then released together → simultaneous press_pulse = 6'b100010, later simultaneous release_pulse = 6'b100010.
